// File: rtl/led_csr_pkg.sv
// Shared field map and mode encoding for the CSR-driven LED block.
// Every LED uses the same mode, duty and rate layout within the CSR word.
package led_csr_pkg;

    localparam int MODE_W   = 2;
    localparam int DUTY_W   = 4;
    localparam int RATE_W   = 2;
    localparam int MODE_LSB = 0;
    localparam int DUTY_LSB = 8;
    localparam int RATE_LSB = 24;

    // Only bits below the reserved field are captured and shadowed.
    localparam int SHADOW_W = RATE_LSB + RATE_W;
    localparam int STEP_W   = 4;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'b11;

    function automatic logic [RATE_W-1:0] rate_of(input logic [SHADOW_W-1:0] word);
        return word[RATE_LSB +: RATE_W];
    endfunction

endpackage

// File: rtl/led_csr_pwm_timebase.sv
// PWM timebase: a prescaler feeding a 16-step counter.
// It produces a tick per step and a wrap on the last tick of each period.
module pwm_timebase
    import led_csr_pkg::*;
#(
    parameter int PWM_PRESCALE = 326
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [STEP_W-1:0] step,
    output logic              tick,
    output logic              wrap
);

    localparam int PRE_W = $clog2(PWM_PRESCALE + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

    logic [PRE_W-1:0]  pre_cnt_reg;
    logic [STEP_W-1:0] step_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg <= '0;
            step_reg    <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
            step_reg    <= step_reg + 1'b1;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    assign tick = (pre_cnt_reg == PRE_LAST);
    assign wrap = tick && (step_reg == {STEP_W{1'b1}});
    assign step = step_reg;

endmodule

// File: rtl/led_csr_driver.sv
// Drives LEDs from a CPU CSR word as off, on, PWM-dimmed or blinking.
// Settings pass through a shadow register that only loads at PWM period start.
module led_csr_driver
    import led_csr_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int PWM_PRESCALE  = 326,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         csr,
    output logic [NUM_LEDS-1:0] leds,
    output logic                pwm_sync
);

    localparam int BLINK_W = $clog2((BLINK_PERIODS << 3) + 1);

    logic [SHADOW_W-1:0] csr_q_reg;
    logic [SHADOW_W-1:0] shadow_reg;
    logic [BLINK_W-1:0]  blink_cnt_reg;
    logic                phase_reg;
    logic                pwm_sync_reg;
    logic [NUM_LEDS-1:0] leds_reg;
    logic [NUM_LEDS-1:0] led_next;

    logic [STEP_W-1:0]   step;
    logic                tick;
    logic                wrap;
    logic [RATE_W-1:0]   rate_cur;
    logic [RATE_W-1:0]   rate_new;
    logic [BLINK_W-1:0]  half_last;
    logic                blink_last;

    // Reserved CSR bits are deliberately dropped.
    logic unused_reserved;
    assign unused_reserved = ^{csr[31:SHADOW_W], tick};

    pwm_timebase #(
        .PWM_PRESCALE(PWM_PRESCALE)
    ) u_timebase (
        .clk  (clk),
        .rst_n(rst_n),
        .step (step),
        .tick (tick),
        .wrap (wrap)
    );

    assign rate_cur   = rate_of(shadow_reg);
    assign rate_new   = rate_of(csr_q_reg);
    assign half_last  = BLINK_W'((BLINK_PERIODS << rate_cur) - 1);
    assign blink_last = (blink_cnt_reg == half_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_q_reg     <= '0;
            shadow_reg    <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            pwm_sync_reg  <= 1'b0;
        end else begin
            csr_q_reg    <= csr[SHADOW_W-1:0];
            pwm_sync_reg <= wrap;
            if (wrap) begin
                shadow_reg <= csr_q_reg;
                // A new blink rate restarts the cycle lit so the change is visible at once.
                if (rate_new != rate_cur) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= 1'b1;
                end else if (blink_last) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            logic [MODE_W-1:0] mode;
            logic [DUTY_W-1:0] duty;
            logic              pwm_on;

            assign mode   = shadow_reg[MODE_LSB + MODE_W*gi +: MODE_W];
            assign duty   = shadow_reg[DUTY_LSB + DUTY_W*gi +: DUTY_W];
            assign pwm_on = (step < duty);

            assign led_next[gi] = (mode == MODE_ON)
                                | ((mode == MODE_PWM)   & pwm_on)
                                | ((mode == MODE_BLINK) & pwm_on & phase_reg);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_reg <= '0;
        end else begin
            leds_reg <= led_next;
        end
    end

    assign leds     = leds_reg;
    assign pwm_sync = pwm_sync_reg;

endmodule

// File: tb/tb_led_csr_driver.sv
// Randomized and directed bench for led_csr_driver against a cycle-indexed reference model.
module tb_led_csr_driver;

    localparam int P   = 2;
    localparam int B   = 2;
    localparam int N   = 4;
    localparam int PER = 16 * P;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  csr = 32'h0;
    logic [N-1:0] leds;
    logic         pwm_sync;

    led_csr_driver #(
        .NUM_LEDS     (N),
        .PWM_PRESCALE (P),
        .BLINK_PERIODS(B)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .csr     (csr),
        .leds    (leds),
        .pwm_sync(pwm_sync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: time is a plain cycle index since reset release.
    logic [25:0]  m_csr_q;
    logic [25:0]  m_shadow;
    int           m_t;
    bit           m_phase;
    int           m_bcnt;
    logic [N-1:0] m_leds;
    bit           m_sync;
    bit           in_reset;

    function automatic logic [N-1:0] expect_leds(input logic [25:0] sh, input int step, input bit ph);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int mode;
            int duty;
            bit lit;
            mode = int'((sh >> (2*i)) & 26'h3);
            duty = int'((sh >> (8 + 4*i)) & 26'hF);
            lit  = (step < duty);
            case (mode)
                0: r[i] = 1'b0;
                1: r[i] = 1'b1;
                2: r[i] = lit;
                default: r[i] = lit & ph;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_csr_q  = '0;
        m_shadow = '0;
        m_t      = 0;
        m_phase  = 1'b0;
        m_bcnt   = 0;
        m_leds   = '0;
        m_sync   = 1'b0;
    endtask

    task automatic model_edge();
        int  step;
        bit  wrap;
        int  rate_cur;
        int  rate_new;
        step = (m_t / P) % 16;
        wrap = ((m_t % PER) == PER - 1);
        m_leds = expect_leds(m_shadow, step, m_phase);
        m_sync = wrap;
        if (wrap) begin
            rate_cur = int'(m_shadow[25:24]);
            rate_new = int'(m_csr_q[25:24]);
            if (rate_new != rate_cur) begin
                m_bcnt  = 0;
                m_phase = 1'b1;
            end else if (m_bcnt == (B << rate_cur) - 1) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end else begin
                m_bcnt++;
            end
            m_shadow = m_csr_q;
        end
        m_csr_q = csr[25:0];
        m_t++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!in_reset) model_edge();
            @(negedge clk);
            check("leds", 32'(leds), 32'(m_leds));
            check("pwm_sync", 32'(pwm_sync), 32'(m_sync));
        end
    endtask

    task automatic segment(input logic [31:0] value, input int cycles);
        csr = value;
        $display("csr=%08h cycles=%0d", value, cycles);
        run(cycles);
    endtask

    initial begin
        in_reset = 1'b1;
        model_reset();
        csr = 32'h0000_0055;
        run(4);
        check("reset_leds", 32'(leds), 32'h0);

        // Release on a falling edge; first load is at cycle 32, LEDs lit from 33.
        rst_n = 1'b1;
        in_reset = 1'b0;
        run(PER + 8);
        check("first_on", 32'(leds), 32'hF);

        segment(32'h0000_3002, 3*PER);
        segment(32'h0000_0002, 2*PER);
        segment(32'h0000_F002, 3*PER);
        segment(32'hFC00_00E4, 3*PER);

        // Mid-period change: switch LED1 on at cycle 10 of a period.
        segment(32'h0000_0000, 2*PER);
        for (int i = 0; i < PER; i++) begin
            if ((m_t % PER) == 10) break;
            run(1);
        end
        segment(32'h0000_0004, PER + 4);

        // Blink at rate 0, then switch to rate 2.
        segment(32'h000F_0030, 8*PER);
        segment(32'h020F_0030, 20*PER);

        for (int s = 0; s < 40; s++) begin
            logic [31:0] v;
            v = $urandom;
            if (($urandom % 4) != 0) v[25:24] = m_csr_q[25:24];
            segment(v, int'($urandom_range(1, 100)));
        end

        // Asynchronous reset between edges while LEDs are lit.
        segment(32'h0000_0055, 2*PER);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_leds", 32'(leds), 32'h0);
        check("async_sync", 32'(pwm_sync), 32'h0);
        in_reset = 1'b1;
        model_reset();
        @(negedge clk);
        run(3);
        rst_n = 1'b1;
        in_reset = 1'b0;
        run(PER + 4);

        for (int s = 0; s < 10; s++) begin
            segment($urandom, int'($urandom_range(1, 80)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
